outlier_drain: RTL and testbench
================================

// Module: outlier_drain
// PURPOSE
//  Downstream of the Controller. After controller done, drains the outlier FIFO (point indices
//  flagged by the distance cores) into a per-point bitmap, then streams out the index of every
//  surviving (inlier) point in ascending order on a valid/ready interface for the point writer.
//  This replaces host-side zeroing of outliers and gives a hardware-filtered cloud.
// PARAMETERS
//  N          16     index / count width (matches Controller point_pos width)
//  MAX_POINTS 17500  bitmap depth; largest supported point_cloud_size
//  WORD_W     32     bitmap word width; NWORDS = ceil(MAX_POINTS/WORD_W)
// PORTS
//  clock            in   1  system clock, rising edge
//  reset            in   1  asynchronous, active-high
//  point_cloud_size in   N  points in current frame; sampled on IDLE->CLEAR
//  controller_done  in   1  Controller done; frame processing finished
//  fifo_empty       in   1  outlier FIFO empty
//  outlier_pos_fifo in   N  FIFO read data; valid 1 cycle after read_fifo with !fifo_empty
//  read_fifo        out  1  FIFO pop request
//  out_valid        out  1  out_pos holds an inlier index
//  out_ready        in   1  consumer accepts beat when out_valid && out_ready
//  out_pos          out  N  inlier point index
//  out_last         out  1  marks final inlier beat of frame
//  outlier_count    out  N  distinct in-range outliers recorded this frame
//  inlier_count     out  N  beats accepted this frame
//  done             out  1  frame drained and fully streamed
//  error            out  1  sticky: an outlier index >= point_cloud_size was received
// BEHAVIOUR
//  Reset (async): state=IDLE; read_fifo, out_valid, out_last, done, error = 0; out_pos,
//   counts = 0. Bitmap contents undefined after reset (always cleared in CLEAR).
//  FSM: IDLE -> CLEAR -> DRAIN -> SCAN -> DONE -> IDLE.
//  IDLE: wait controller_done=1 -> latch size (saturate at MAX_POINTS), zero counts/error.
//  CLEAR: one bitmap word zeroed per cycle, words 0..NWORDS-1; then DRAIN. Size=0 still clears.
//  DRAIN: read_fifo = !fifo_empty (combinational on registered state). Data registered one
//   cycle later sets bitmap bit. Bit already set -> no count change (duplicate). Index >= size
//   -> dropped, error=1. Leave DRAIN when fifo_empty=1 and no read in flight.
//  SCAN: idx counter 0..size-1, one index examined per cycle when output slot free. Outlier bit
//   set -> skip (no beat, 1 cycle). Inlier -> out_valid=1, out_pos=idx; out_last=1 iff no
//   inlier remains above idx (look-ahead over remaining bits, or hold last candidate one beat).
//  Handshake: out_pos/out_last stable while out_valid && !out_ready; out_valid never drops
//   without acceptance. Throughput 1 beat/cycle with out_ready held high.
//  After idx = size-1 examined and last beat accepted -> DONE. Zero inliers: no beats, DONE.
//  DONE: done=1, counts held; controller_done=0 -> IDLE (done=0). Counts hold until next CLEAR.
//  inlier_count + outlier_count == size at DONE when error=0.
//  controller_done dropping mid-frame is ignored until DONE. fifo_empty rising mid-read: the
//   in-flight word is still captured. Async reset mid-frame aborts immediately to IDLE.
//  Counters width N; size <= MAX_POINTS < 2^N so no wrap.
// TESTING
//  1. size=20, FIFO {3,7,19}, out_ready=1 -> 17 beats 0..18 skipping 3,7; out_last on 18;
//     outlier_count=3, inlier_count=17, done=1, error=0.
//  2. size=20, FIFO {5,5,5} -> outlier_count=1, 19 beats, duplicates not counted.
//  3. size=10, FIFO {2,25} -> error=1, 25 ignored, 9 beats, outlier_count=1.
//  4. size=8, FIFO {0..7} -> zero beats, out_last never asserted, inlier_count=0, done=1.
//  5. size=16, empty FIFO, out_ready toggled 1010.. -> 16 beats 0..15 in order, out_pos
//     stable across stalls, out_last on 15 only.
//  6. Assert reset during SCAN at beat 4 -> all outputs 0 next edge; rerun frame after
//     deassert -> bitmap re-cleared, results identical to clean run.

Source files
------------

// File: rtl/outlier_drain.sv
// Drains the outlier FIFO into a per-point bitmap, then streams every inlier index in
// ascending order on a valid/ready port, flagging the final beat with out_last.
module outlier_drain #(
    parameter int N          = 16,
    parameter int MAX_POINTS = 17500,
    parameter int WORD_W     = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] point_cloud_size,
    input  logic         controller_done,
    input  logic         fifo_empty,
    input  logic [N-1:0] outlier_pos_fifo,
    output logic         read_fifo,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_pos,
    output logic         out_last,
    output logic [N-1:0] outlier_count,
    output logic [N-1:0] inlier_count,
    output logic         done,
    output logic         error
);

    localparam int NWORDS = (MAX_POINTS + WORD_W - 1) / WORD_W;
    localparam int AW     = $clog2(NWORDS);
    localparam int LW     = $clog2(WORD_W);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_SCAN  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [AW-1:0] word_of(input logic [N-1:0] idx);
        return idx[LW +: AW];
    endfunction

    logic [2:0]        state_reg;
    logic [N-1:0]      size_reg;
    logic [AW-1:0]     clr_addr_reg;
    logic              rd_pend_reg, p_vld_reg;
    logic [N-1:0]      p_idx_reg;
    logic              fwd_vld_reg;
    logic [AW-1:0]     fwd_addr_reg;
    logic [WORD_W-1:0] fwd_data_reg;
    logic [N-1:0]      scan_idx_reg, b_idx_reg, cand_idx_reg;
    logic              b_vld_reg, cand_vld_reg;
    logic              out_valid_reg, out_last_reg, error_reg;
    logic [N-1:0]      out_pos_reg, outlier_count_reg, inlier_count_reg;

    // Bitmap storage: one write port, registered read.
    logic [WORD_W-1:0] mem [NWORDS];
    logic [WORD_W-1:0] rd_data_reg;
    logic [AW-1:0]     rd_addr, wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_en;

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data_reg <= mem[rd_addr];
    end

    logic              adv, issue_done, scan_end, b_inlier;
    logic [WORD_W-1:0] p_word, bit_mask;
    logic              p_in_range, p_dup;

    assign adv        = !out_valid_reg || out_ready;
    assign issue_done = scan_idx_reg >= size_reg;
    assign scan_end   = issue_done && !b_vld_reg;
    assign b_inlier   = b_vld_reg && !rd_data_reg[b_idx_reg[LW-1:0]];

    // A write issued last cycle is not yet visible to the read issued in the same cycle.
    assign p_word     = (fwd_vld_reg && fwd_addr_reg == word_of(p_idx_reg)) ? fwd_data_reg : rd_data_reg;
    assign p_in_range = p_idx_reg < size_reg;
    assign p_dup      = p_word[p_idx_reg[LW-1:0]];
    assign bit_mask   = WORD_W'(1) << p_idx_reg[LW-1:0];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr_reg;
        wr_data = '0;
        rd_addr = word_of(scan_idx_reg);
        case (state_reg)
            S_CLEAR: wr_en = 1'b1;
            S_DRAIN: begin
                rd_addr = word_of(outlier_pos_fifo);
                if (p_vld_reg && p_in_range) begin
                    wr_en   = 1'b1;
                    wr_addr = word_of(p_idx_reg);
                    wr_data = p_word | bit_mask;
                end
            end
            S_SCAN:  rd_addr = adv ? word_of(scan_idx_reg) : word_of(b_idx_reg);
            default: ;
        endcase
    end

    assign read_fifo     = (state_reg == S_DRAIN) && !fifo_empty;
    assign done          = (state_reg == S_DONE);
    assign out_valid     = out_valid_reg;
    assign out_pos       = out_pos_reg;
    assign out_last      = out_last_reg;
    assign outlier_count = outlier_count_reg;
    assign inlier_count  = inlier_count_reg;
    assign error         = error_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            size_reg          <= '0;
            clr_addr_reg      <= '0;
            rd_pend_reg       <= 1'b0;
            p_vld_reg         <= 1'b0;
            p_idx_reg         <= '0;
            fwd_vld_reg       <= 1'b0;
            fwd_addr_reg      <= '0;
            fwd_data_reg      <= '0;
            scan_idx_reg      <= '0;
            b_idx_reg         <= '0;
            cand_idx_reg      <= '0;
            b_vld_reg         <= 1'b0;
            cand_vld_reg      <= 1'b0;
            out_valid_reg     <= 1'b0;
            out_last_reg      <= 1'b0;
            out_pos_reg       <= '0;
            outlier_count_reg <= '0;
            inlier_count_reg  <= '0;
            error_reg         <= 1'b0;
        end else begin
            rd_pend_reg  <= read_fifo;
            p_vld_reg    <= rd_pend_reg && (state_reg == S_DRAIN);
            p_idx_reg    <= outlier_pos_fifo;
            fwd_vld_reg  <= wr_en && (state_reg == S_DRAIN);
            fwd_addr_reg <= wr_addr;
            fwd_data_reg <= wr_data;
            case (state_reg)
                S_IDLE: if (controller_done) begin
                    size_reg          <= (point_cloud_size > N'(MAX_POINTS)) ? N'(MAX_POINTS) : point_cloud_size;
                    outlier_count_reg <= '0;
                    inlier_count_reg  <= '0;
                    error_reg         <= 1'b0;
                    clr_addr_reg      <= '0;
                    state_reg         <= S_CLEAR;
                end
                S_CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                    if (clr_addr_reg == AW'(NWORDS - 1)) state_reg <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (p_vld_reg) begin
                        if (!p_in_range) error_reg <= 1'b1;
                        else if (!p_dup) outlier_count_reg <= outlier_count_reg + 1'b1;
                    end
                    if (fifo_empty && !rd_pend_reg && !p_vld_reg) begin
                        scan_idx_reg <= '0;
                        b_vld_reg    <= 1'b0;
                        cand_vld_reg <= 1'b0;
                        state_reg    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (out_valid_reg && out_ready) inlier_count_reg <= inlier_count_reg + 1'b1;
                    // Each inlier is held as a candidate until the next one (or the end) proves its last flag.
                    if (adv) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        if (b_inlier) begin
                            if (cand_vld_reg) begin
                                out_valid_reg <= 1'b1;
                                out_pos_reg   <= cand_idx_reg;
                            end
                            cand_idx_reg <= b_idx_reg;
                            cand_vld_reg <= 1'b1;
                        end else if (scan_end && cand_vld_reg) begin
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= 1'b1;
                            out_pos_reg   <= cand_idx_reg;
                            cand_vld_reg  <= 1'b0;
                        end
                        if (!issue_done) begin
                            b_vld_reg    <= 1'b1;
                            b_idx_reg    <= scan_idx_reg;
                            scan_idx_reg <= scan_idx_reg + 1'b1;
                        end else begin
                            b_vld_reg <= 1'b0;
                        end
                        if (scan_end && !cand_vld_reg) state_reg <= S_DONE;
                    end
                end
                S_DONE: if (!controller_done) state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_outlier_drain.sv
// Self-checking bench for outlier_drain: directed frames plus random frames compared
// against a set-based reference model of the expected inlier stream and counts.
module tb_outlier_drain;

    localparam int MAXP = 17500;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] point_cloud_size = '0;
    logic        controller_done = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] outlier_pos_fifo = '0;
    logic        read_fifo;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_pos;
    logic        out_last;
    logic [15:0] outlier_count;
    logic [15:0] inlier_count;
    logic        done;
    logic        error;

    outlier_drain dut (
        .clock(clock), .reset(reset), .point_cloud_size(point_cloud_size),
        .controller_done(controller_done), .fifo_empty(fifo_empty),
        .outlier_pos_fifo(outlier_pos_fifo), .read_fifo(read_fifo),
        .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
        .out_last(out_last), .outlier_count(outlier_count),
        .inlier_count(inlier_count), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outlier FIFO: data appears the cycle after a granted pop.
    int fifo_q[$];
    logic pop_req = 1'b0;
    always @(negedge clock) pop_req <= read_fifo && !fifo_empty;
    always @(posedge clock) begin
        if (pop_req && fifo_q.size() > 0) outlier_pos_fifo <= 16'(fifo_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    int ready_mode = 0;
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Beat monitor and stall-stability checks.
    int beat_pos[$];
    int beat_last[$];
    logic        hold_pend = 1'b0;
    logic [15:0] held_pos;
    logic        held_last;
    always @(negedge clock) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_pos", int'(out_pos), int'(held_pos));
                check("stall_last", int'(out_last), int'(held_last));
            end
            if (out_valid && out_ready) begin
                beat_pos.push_back(int'(out_pos));
                beat_last.push_back(int'(out_last));
            end
            hold_pend = out_valid && !out_ready;
            held_pos  = out_pos;
            held_last = out_last;
        end
    end

    task automatic run_frame(input string tag, input int size, input int list[$], input int mode);
        bit mark[];
        int exp_beats[$];
        int exp_oc, exp_err, eff, cyc, bad;
        eff = (size > MAXP) ? MAXP : size;
        mark = new[eff + 1];
        exp_oc = 0;
        exp_err = 0;
        foreach (list[i]) begin
            if (list[i] >= eff) exp_err = 1;
            else if (!mark[list[i]]) begin
                mark[list[i]] = 1'b1;
                exp_oc++;
            end
        end
        for (int i = 0; i < eff; i++) if (!mark[i]) exp_beats.push_back(i);

        beat_pos.delete();
        beat_last.delete();
        fifo_q = list;
        ready_mode = mode;
        @(posedge clock); #1;
        point_cloud_size = 16'(size);
        controller_done = 1'b1;
        cyc = 0;
        while (!done && cyc < 40000) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_beats"}, beat_pos.size(), exp_beats.size());
        bad = 0;
        for (int i = 0; i < exp_beats.size() && i < beat_pos.size() && bad == 0; i++) begin
            bad = errors;
            check({tag, "_pos"}, beat_pos[i], exp_beats[i]);
            check({tag, "_last"}, beat_last[i], (i == exp_beats.size() - 1) ? 1 : 0);
            bad = errors - bad;
        end
        check({tag, "_outliers"}, int'(outlier_count), exp_oc);
        check({tag, "_inliers"}, int'(inlier_count), exp_beats.size());
        check({tag, "_error"}, int'(error), exp_err);
        check({tag, "_fifo_left"}, fifo_q.size(), 0);
        $display("frame %s size=%0d outliers=%0d beats=%0d error=%0d", tag, size,
                 outlier_count, beat_pos.size(), error);
        controller_done = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check({tag, "_done_clr"}, int'(done), 0);
        check({tag, "_counts_hold"}, int'(inlier_count), exp_beats.size());
    endtask

    initial begin
        int lst[$];
        int sz, cyc;
        repeat (3) @(negedge clock);
        check("rst_valid", int'(out_valid), 0);
        check("rst_read", int'(read_fifo), 0);
        check("rst_done", int'(done), 0);
        check("rst_counts", int'(outlier_count) + int'(inlier_count), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_frame("t1", 20, '{3, 7, 19}, 0);
        run_frame("t2_dup", 20, '{5, 5, 5}, 0);
        run_frame("t3_range", 10, '{2, 25}, 0);
        run_frame("t4_all", 8, '{0, 1, 2, 3, 4, 5, 6, 7}, 0);
        run_frame("t5_stall", 16, '{}, 1);
        run_frame("t_zero", 0, '{}, 0);
        run_frame("t_cross", 70, '{31, 32, 33, 63, 64, 32, 69}, 2);

        // Abort mid-scan, then rerun the same frame.
        beat_pos.delete();
        fifo_q = '{3, 7, 19};
        ready_mode = 0;
        @(posedge clock); #1;
        point_cloud_size = 16'd20;
        controller_done = 1'b1;
        cyc = 0;
        while (beat_pos.size() < 4 && cyc < 5000) begin
            @(negedge clock);
            cyc++;
        end
        check("abort_reached", beat_pos.size(), 4);
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_outputs", int'({out_valid, out_last, done, error, read_fifo}), 0);
        check("abort_pos", int'(out_pos), 0);
        check("abort_counts", int'(outlier_count) + int'(inlier_count), 0);
        controller_done = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_frame("t6_rerun", 20, '{3, 7, 19}, 0);

        for (int f = 0; f < 6; f++) begin
            lst.delete();
            sz = $urandom_range(1, 300);
            for (int k = $urandom_range(0, 12); k > 0; k--) begin
                lst.push_back($urandom_range(0, sz + 8));
                if ($urandom_range(0, 3) == 0) lst.push_back(lst[lst.size() - 1]);
            end
            run_frame($sformatf("rnd%0d", f), sz, lst, 2);
        end

        run_frame("t_sat", 20000, '{0, 17499, 17500}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
